// File: rtl/sad_pkg.sv
// Shared SAD helpers: default geometry and width derivations.
// Also used by the disparity-selection block so both sides agree on widths.
package sad_pkg;

    localparam int unsigned DefaultWindowSize = 5;
    localparam int unsigned DefaultNumBits    = 8;

    // Ceiling log2; 0 and 1 both map to 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned col_bits(input int unsigned num_bits,
                                             input int unsigned window_size);
        return num_bits + clog2(window_size);
    endfunction

    function automatic int unsigned sad_bits(input int unsigned num_bits,
                                             input int unsigned window_size);
        return num_bits + clog2(window_size * window_size);
    endfunction

endpackage

// File: rtl/sad_window_accumulator_if.sv
// Column-in / window-cost-out bundle for sad_window_accumulator.
// master drives columns; slave (the accumulator) returns costs.
interface sad_window_accumulator_if
    import sad_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = DefaultWindowSize,
    parameter int unsigned NUM_BITS    = DefaultNumBits
) ();

    localparam int unsigned COL_BITS = col_bits(NUM_BITS, WINDOW_SIZE);
    localparam int unsigned SAD_BITS = sad_bits(NUM_BITS, WINDOW_SIZE);

    logic                            in_valid;
    logic                            line_start;
    logic [NUM_BITS*WINDOW_SIZE-1:0] in1;
    logic [NUM_BITS*WINDOW_SIZE-1:0] in2;
    logic                            out_valid;
    logic [SAD_BITS-1:0]             sad;
    logic [COL_BITS-1:0]             col_sad;

    modport master (
        output in_valid, line_start, in1, in2,
        input  out_valid, sad, col_sad
    );

    modport slave (
        input  in_valid, line_start, in1, in2,
        output out_valid, sad, col_sad
    );

endinterface

// File: rtl/abs_diff_lane.sv
// Registered per-lane |a - b|; SAD_TRUNCATED_DIFF_EN clamps the result at TRUNC_VAL.
// Without the macro TRUNC_VAL has no effect.
module abs_diff_lane #(
    parameter int unsigned NUM_BITS  = 8,
    parameter int unsigned TRUNC_VAL = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [NUM_BITS-1:0] a_i,
    input  logic [NUM_BITS-1:0] b_i,
    output logic [NUM_BITS-1:0] diff_o
);

`ifdef SAD_TRUNCATED_DIFF_EN
    localparam bit TruncEn = 1'b1;
`else
    localparam bit TruncEn = 1'b0;
`endif

    localparam logic [NUM_BITS-1:0] TruncVal = NUM_BITS'(TRUNC_VAL);

    logic [NUM_BITS-1:0] abs_diff;
    logic [NUM_BITS-1:0] diff_d, diff_q;

    always_comb begin
        abs_diff = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        diff_d   = (TruncEn && (abs_diff > TruncVal)) ? TruncVal : abs_diff;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diff_q <= '0;
        end else if (en_i) begin
            diff_q <= diff_d;
        end
    end

    assign diff_o = diff_q;

endmodule

// File: rtl/sad_window_accumulator.sv
// Sliding WINDOW_SIZE x WINDOW_SIZE SAD: lane diffs (S1), column sum (S2), window update (S3).
// Optional truncated differences via SAD_TRUNCATED_DIFF_EN (see abs_diff_lane).
module sad_window_accumulator
    import sad_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = DefaultWindowSize,
    parameter int unsigned NUM_BITS    = DefaultNumBits,
    parameter int unsigned TRUNC_VAL   = 32
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    sad_window_accumulator_if.slave bus_io
);

    localparam int unsigned COL_BITS  = col_bits(NUM_BITS, WINDOW_SIZE);
    localparam int unsigned SAD_BITS  = sad_bits(NUM_BITS, WINDOW_SIZE);
    localparam int unsigned FILL_BITS = clog2(WINDOW_SIZE + 1);
    localparam logic [FILL_BITS-1:0] FillFull = FILL_BITS'(WINDOW_SIZE);

    // S1: per-lane absolute differences
    logic [NUM_BITS-1:0] lane_diff [WINDOW_SIZE];
    logic                s1_valid_q, s1_start_q;

    for (genvar i = 0; i < WINDOW_SIZE; i++) begin : g_lane
        abs_diff_lane #(
            .NUM_BITS  (NUM_BITS),
            .TRUNC_VAL (TRUNC_VAL)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (bus_io.in_valid),
            .a_i    (bus_io.in1[NUM_BITS*i +: NUM_BITS]),
            .b_i    (bus_io.in2[NUM_BITS*i +: NUM_BITS]),
            .diff_o (lane_diff[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_start_q <= 1'b0;
        end else begin
            s1_valid_q <= bus_io.in_valid;
            s1_start_q <= bus_io.in_valid & bus_io.line_start;
        end
    end

    // S2: column cost
    logic [COL_BITS-1:0] col_sum_d, s2_col_q;
    logic                s2_valid_q, s2_start_q;

    always_comb begin
        col_sum_d = '0;
        for (int i = 0; i < WINDOW_SIZE; i++) begin
            col_sum_d = col_sum_d + COL_BITS'(lane_diff[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_start_q <= 1'b0;
            s2_col_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_start_q <= s1_start_q;
            if (s1_valid_q) begin
                s2_col_q <= col_sum_d;
            end
        end
    end

    // S3: sliding window; hist_q[0] is the newest column, hist_q[WINDOW_SIZE-1] the oldest
    logic [COL_BITS-1:0]  hist_d [WINDOW_SIZE];
    logic [COL_BITS-1:0]  hist_q [WINDOW_SIZE];
    logic [FILL_BITS-1:0] fill_d, fill_q;
    logic [SAD_BITS-1:0]  acc_d, acc_q;
    logic [SAD_BITS-1:0]  sad_q;
    logic [COL_BITS-1:0]  col_sad_q;
    logic                 out_valid_d, out_valid_q;

    always_comb begin
        hist_d      = hist_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        if (s2_valid_q) begin
            if (s2_start_q) begin
                for (int i = 0; i < WINDOW_SIZE; i++) begin
                    hist_d[i] = '0;
                end
                hist_d[0] = s2_col_q;
                acc_d     = SAD_BITS'(s2_col_q);
                fill_d    = FILL_BITS'(1);
            end else begin
                hist_d[0] = s2_col_q;
                for (int i = 1; i < WINDOW_SIZE; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                if (fill_q == FillFull) begin
                    // The oldest column is already part of acc_q, so this cannot underflow.
                    acc_d = acc_q + SAD_BITS'(s2_col_q) - SAD_BITS'(hist_q[WINDOW_SIZE-1]);
                end else begin
                    acc_d  = acc_q + SAD_BITS'(s2_col_q);
                    fill_d = fill_q + FILL_BITS'(1);
                end
            end
            out_valid_d = (fill_d == FillFull);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                hist_q[i] <= '0;
            end
            fill_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            sad_q       <= '0;
            col_sad_q   <= '0;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                sad_q     <= acc_d;
                col_sad_q <= s2_col_q;
            end
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.sad       = sad_q;
    assign bus_io.col_sad   = col_sad_q;

endmodule

// File: tb/tb_sad_window_accumulator.sv
// Directed bench for sad_window_accumulator with hand-computed window costs.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sad_window_accumulator;
    import sad_pkg::*;

    localparam int unsigned WS = 5;
    localparam int unsigned NB = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    sad_window_accumulator_if #(.WINDOW_SIZE(WS), .NUM_BITS(NB)) bus ();

    sad_window_accumulator #(
        .WINDOW_SIZE (WS),
        .NUM_BITS    (NB),
        .TRUNC_VAL   (32)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus_io (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic drive(input int v, input int ls, input int unsigned a, input int unsigned b);
        bus.in_valid   = (v != 0);
        bus.line_start = (ls != 0);
        bus.in1        = {WS{NB'(a)}};
        bus.in2        = {WS{NB'(b)}};
    endtask

    // One clock with the given column on the inputs, then check out_valid.
    task automatic col(input string tag, input int v, input int ls, input int unsigned a,
                       input int unsigned b, input int unsigned exp_ov);
        drive(v, ls, a, b);
        @(posedge clk_i);
        #1;
        check_eq(tag, int'(bus.out_valid), exp_ov);
    endtask

    task automatic check_out(input string tag, input int unsigned exp_sad,
                             input int unsigned exp_col);
        check_eq({tag, "_sad"}, int'(bus.sad), exp_sad);
        check_eq({tag, "_col"}, int'(bus.col_sad), exp_col);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_ov", int'(bus.out_valid), 0);
        check_out("rst", 0, 0);
        rst_ni = 1'b1;

        // Five 10-3 columns, then a 0-255 column
        col("t1_c1", 1, 1, 10, 3, 0);
        col("t1_c2", 1, 0, 10, 3, 0);
        col("t1_c3", 1, 0, 10, 3, 0);
        col("t1_c4", 1, 0, 10, 3, 0);
        col("t1_c5", 1, 0, 10, 3, 0);
        col("t1_c6", 1, 0, 0, 255, 0);
        col("t1_w5", 0, 0, 0, 0, 1);
        check_out("t1_w5", 175, 35);
        col("t1_w6", 0, 0, 0, 0, 1);
        check_out("t1_w6", 1415, 1275);
        col("t1_hold", 0, 0, 0, 0, 0);
        check_out("t1_hold", 1415, 1275);

        // New line with two bubbles between columns 4 and 5
        col("t2_c1", 1, 1, 10, 3, 0);
        col("t2_c2", 1, 0, 10, 3, 0);
        col("t2_c3", 1, 0, 10, 3, 0);
        col("t2_c4", 1, 0, 10, 3, 0);
        col("t2_b1", 0, 0, 0, 0, 0);
        col("t2_b2", 0, 0, 0, 0, 0);
        col("t2_c5", 1, 0, 10, 3, 0);
        col("t2_b3", 0, 0, 0, 0, 0);
        col("t2_w5", 0, 0, 0, 0, 1);
        check_out("t2_w5", 175, 35);

        // line_start again on column 3; ls on a bubble must be ignored
        col("t3_c1", 1, 1, 50, 0, 0);
        col("t3_c2", 1, 0, 50, 0, 0);
        col("t3_c3", 1, 1, 2, 0, 0);
        col("t3_c4", 1, 0, 2, 0, 0);
        col("t3_c5", 1, 0, 2, 0, 0);
        col("t3_bls", 0, 1, 0, 0, 0);
        col("t3_c6", 1, 0, 2, 0, 0);
        col("t3_c7", 1, 0, 2, 0, 0);
        col("t3_c8", 1, 0, 4, 0, 0);
        col("t3_w7", 0, 0, 0, 0, 1);
        check_out("t3_w7", 50, 10);
        col("t3_w8", 0, 0, 0, 0, 1);
        check_out("t3_w8", 60, 20);

        // Reset with two tokens in flight, then five |diff|=1 columns, no line_start
        col("t4_x1", 1, 0, 100, 0, 0);
        col("t4_x2", 1, 0, 100, 0, 0);
        rst_ni = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        check_eq("t4_rst_ov", int'(bus.out_valid), 0);
        check_out("t4_rst", 0, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        col("t4_d1", 1, 0, 5, 6, 0);
        col("t4_d2", 1, 0, 5, 6, 0);
        col("t4_d3", 1, 0, 6, 5, 0);
        col("t4_d4", 1, 0, 5, 6, 0);
        col("t4_d5", 1, 0, 6, 5, 0);
        col("t4_b1", 0, 0, 0, 0, 0);
        col("t4_w5", 0, 0, 0, 0, 1);
        check_out("t4_w5", 25, 5);

        // Large differences: clamped to 32 per lane only with truncation enabled
        col("t5_c1", 1, 1, 200, 0, 0);
        col("t5_c2", 1, 0, 200, 0, 0);
        col("t5_c3", 1, 0, 200, 0, 0);
        col("t5_c4", 1, 0, 200, 0, 0);
        col("t5_c5", 1, 0, 200, 0, 0);
        col("t5_b1", 0, 0, 0, 0, 0);
        col("t5_w5", 0, 0, 0, 0, 1);
`ifdef SAD_TRUNCATED_DIFF_EN
        check_out("t5_w5", 800, 160);
`else
        check_out("t5_w5", 5000, 1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
